// File: rtl/pc_pkg.sv
// Shared types and field positions for the program-counter / fetch stage.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned COND_LSB    = 5;
    localparam int unsigned COND_MSB    = 23;
    localparam int unsigned UNCOND_MSB  = 25;
    localparam int unsigned BR_SHIFT    = 2;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-to-decode handshake: registered {pc, instr} under valid/ready.
interface pc_fetch_unit_if #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned INSTR_W = 32
);
    logic               f_valid;
    logic               f_ready;
    logic [ADDR_W-1:0]  f_pc;
    logic [INSTR_W-1:0] f_instr;

    modport master (output f_valid, output f_pc, output f_instr, input f_ready);
    modport slave  (input f_valid, input f_pc, input f_instr, output f_ready);
endinterface

// File: rtl/branch_target_calc.sv
// Combinational branch target: PC-relative (cond/uncond) or register, plus BR misalignment flag.
module branch_target_calc
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned INSTR_W = 32
) (
    input  logic [ADDR_W-1:0]  br_pc,
    input  logic [INSTR_W-1:0] br_instr,
    input  logic               br_uncond,
    input  logic               br_reg,
    input  logic [ADDR_W-1:0]  br_reg_val,
    output logic [ADDR_W-1:0]  target_c,
    output logic               misalign_c
);

    logic [ADDR_W-1:0] cond_off;
    logic [ADDR_W-1:0] uncond_off;
    logic [ADDR_W-1:0] offset;
    logic              unused_bits;

    // Opcode bits above the widest offset field carry no target information.
    assign unused_bits = ^br_instr[INSTR_W-1:UNCOND_MSB+1];

    always_comb begin
        cond_off   = ADDR_W'($signed(br_instr[COND_MSB:COND_LSB])) << BR_SHIFT;
        uncond_off = ADDR_W'($signed(br_instr[UNCOND_MSB:0])) << BR_SHIFT;
        offset     = br_uncond ? uncond_off : cond_off;
        // Register target drops its low bits rather than faulting; misalign_c reports it.
        if (br_reg) begin
            target_c = {br_reg_val[ADDR_W-1:BR_SHIFT], BR_SHIFT'(0)};
        end else begin
            target_c = br_pc + offset;
        end
        misalign_c = br_reg & (|br_reg_val[BR_SHIFT-1:0]);
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch output register with decode handshake and branch redirect.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 64,
    parameter int unsigned       INSTR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    pc_fetch_unit_if.master    dec,
    input  logic               br_valid,
    input  logic               br_taken,
    input  logic               br_uncond,
    input  logic               br_reg,
    input  logic [ADDR_W-1:0]  br_pc,
    input  logic [INSTR_W-1:0] br_instr,
    input  logic [ADDR_W-1:0]  br_reg_val,
    output logic               br_misalign
);

    fetch_state_e       state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic               f_valid_q;
    logic [ADDR_W-1:0]  f_pc_q;
    logic [INSTR_W-1:0] f_instr_q;
    logic               misalign_q;

    logic [ADDR_W-1:0]  target_c;
    logic               misalign_c;
    logic               redirect_c;
    logic               capture_c;

    branch_target_calc #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_target (
        .br_pc      (br_pc),
        .br_instr   (br_instr),
        .br_uncond  (br_uncond),
        .br_reg     (br_reg),
        .br_reg_val (br_reg_val),
        .target_c   (target_c),
        .misalign_c (misalign_c)
    );

    assign redirect_c = br_valid & br_taken;
    assign capture_c  = (state_q != BOOT) & (~f_valid_q | dec.f_ready);

    // Redirect outranks everything; otherwise BOOT idles one cycle, RUN/HOLD capture when the slot frees.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VEC;
            f_valid_q  <= 1'b0;
            f_pc_q     <= '0;
            f_instr_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            if (redirect_c) begin
                state_q    <= RUN;
                pc_q       <= target_c;
                f_valid_q  <= 1'b0;
                misalign_q <= misalign_c;
            end else begin
                case (state_q)
                    BOOT: state_q <= RUN;
                    RUN, HOLD: begin
                        if (capture_c) begin
                            state_q   <= RUN;
                            f_valid_q <= 1'b1;
                            f_pc_q    <= pc_q;
                            f_instr_q <= imem_instr;
                            pc_q      <= pc_q + ADDR_W'(INSTR_BYTES);
                        end else begin
                            state_q <= HOLD;
                        end
                    end
                    default: state_q <= BOOT;
                endcase
            end
        end
    end

    assign imem_addr   = pc_q;
    assign dec.f_valid = f_valid_q;
    assign dec.f_pc    = f_pc_q;
    assign dec.f_instr = f_instr_q;
    assign br_misalign = misalign_q;

endmodule
